// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage and IF/ID pipeline register.
// Owns the PC, drives imem_addr, registers the fetched word into IF/ID.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall             freeze PC, IF/ID and fetch state
//   hlt               latched halt from the hazard unit; enters HALTED
//   redirect          taken branch resolved in EX
//   redirect_pc       branch target (bit 0 forced to 0)
//   imem_addr         instruction-memory address (= pc)
//   imem_data         instruction word at imem_addr (same-cycle read)
//   if_id_instr       registered instruction for decode
//   if_id_pc_plus2    registered PC+2 of that instruction
//   if_id_valid       1 = real instruction, 0 = bubble
//   flush             high in any cycle where a redirect is accepted
//   pc                current PC register
//   halted            1 while in HALTED
//   fetch_count       valid instructions written into IF/ID (saturating)

module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        hlt,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc_plus2,
    output logic        if_id_valid,
    output logic        flush,
    output logic [15:0] pc,
    output logic        halted,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_HLT_SEEN = 2'd1,
        S_HALTED   = 2'd2
    } state_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc_plus2;
        logic        valid;
    } if_id_t;

    localparam if_id_t BUBBLE = '0;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] pc_q;
    logic [15:0] pc_d;
    if_id_t      ifid_q;
    if_id_t      ifid_d;
    logic [15:0] cnt_q;
    logic        cnt_inc;
    logic        halted_q;

    logic [15:0] pc_plus2;
    logic [15:0] target;
    logic        is_hlt_word;
    logic        take_redirect;

    // Bit 0 of the target is architecturally ignored.
    logic        unused_rpc_lsb;
    assign unused_rpc_lsb = redirect_pc[0];

    assign pc_plus2    = pc_q + 16'd2;
    assign target      = {redirect_pc[15:1], 1'b0};
    assign is_hlt_word = (imem_data[15:12] == 4'hF);

    // hlt outranks redirect, and HALTED ignores redirects altogether.
    assign take_redirect = redirect & ~hlt & (state_q != S_HALTED);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ifid_d  = ifid_q;
        cnt_inc = 1'b0;

        if (hlt) begin
            state_d = S_HALTED;
            ifid_d  = BUBBLE;
        end else if (state_q == S_HALTED) begin
            ifid_d = BUBBLE;
        end else if (redirect) begin
            state_d = S_RUN;
            pc_d    = target;
            ifid_d  = BUBBLE;
        end else if (stall) begin
            ifid_d = ifid_q;
        end else begin
            case (state_q)
                S_RUN: begin
                    ifid_d.instr    = imem_data;
                    ifid_d.pc_plus2 = pc_plus2;
                    ifid_d.valid    = 1'b1;
                    cnt_inc         = 1'b1;
                    // An HLT word parks the PC on itself until
                    // the hazard unit raises hlt or EX redirects.
                    if (is_hlt_word) begin
                        state_d = S_HLT_SEEN;
                    end else begin
                        pc_d = pc_plus2;
                    end
                end
                default: begin
                    ifid_d = BUBBLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_RUN;
            pc_q     <= RESET_PC;
            ifid_q   <= BUBBLE;
            cnt_q    <= 16'h0000;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ifid_q   <= ifid_d;
            halted_q <= (state_d == S_HALTED);
            if (cnt_inc && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign flush          = take_redirect & ~rst;
    assign pc             = pc_q;
    assign imem_addr      = pc_q;
    assign if_id_instr    = ifid_q.instr;
    assign if_id_pc_plus2 = ifid_q.pc_plus2;
    assign if_id_valid    = ifid_q.valid;
    assign halted         = halted_q;
    assign fetch_count    = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed plus randomized bench for fetch_stage,
// checked every cycle against a behavioural model of the fetch rules.

module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        hlt = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc_plus2;
    logic        if_id_valid;
    logic        flush;
    logic [15:0] pc;
    logic        halted;
    logic [15:0] fetch_count;

    logic [15:0] mem [0:65535];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    fetch_stage #(.RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .hlt            (hlt),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus2 (if_id_pc_plus2),
        .if_id_valid    (if_id_valid),
        .flush          (flush),
        .pc             (pc),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    // Behavioural model of the architectural state.
    bit          m_known = 0;
    int          m_pc;
    bit          m_parked;
    bit          m_stopped;
    int          m_instr;
    int          m_pp2;
    bit          m_valid;
    int          m_count;

    task automatic m_bubble();
        m_instr = 0;
        m_pp2   = 0;
        m_valid = 0;
    endtask

    always @(posedge clk) begin
        int w;
        if (rst) begin
            m_known   = 1;
            m_pc      = 0;
            m_parked  = 0;
            m_stopped = 0;
            m_count   = 0;
            m_bubble();
        end else if (m_known) begin
            if (hlt) begin
                m_stopped = 1;
                m_parked  = 0;
                m_bubble();
            end else if (m_stopped) begin
                m_bubble();
            end else if (redirect) begin
                m_pc     = int'(redirect_pc) & 16'hFFFE;
                m_parked = 0;
                m_bubble();
            end else if (stall) begin
                // everything holds
            end else if (m_parked) begin
                m_bubble();
            end else begin
                w       = int'(mem[m_pc]);
                m_instr = w;
                m_pp2   = (m_pc + 2) % 65536;
                m_valid = 1;
                if (m_count < 65535) m_count = m_count + 1;
                if ((w >> 12) == 15) m_parked = 1;
                else m_pc = (m_pc + 2) % 65536;
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the clock edge.
    always @(negedge clk) begin
        if (m_known) begin
            chk("pc",        pc,             16'(m_pc));
            chk("imem_addr", imem_addr,      16'(m_pc));
            chk("instr",     if_id_instr,    16'(m_instr));
            chk("pc_plus2",  if_id_pc_plus2, 16'(m_pp2));
            chk("valid",     {15'd0, if_id_valid}, {15'd0, m_valid});
            chk("halted",    {15'd0, halted},      {15'd0, m_stopped});
            chk("count",     fetch_count,    16'(m_count));
            chk("flush",     {15'd0, flush},
                {15'd0, (!rst && redirect && !hlt && !m_stopped)});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic r, input logic s, input logic h,
                         input logic rd, input logic [15:0] rp);
        rst         = r;
        stall       = s;
        hlt         = h;
        redirect    = rd;
        redirect_pc = rp;
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
        mem[16'h0000] = 16'h1123;
        mem[16'h0002] = 16'h2456;
        mem[16'h0004] = 16'h3789;
        mem[16'h0006] = 16'h4000;
        mem[16'h0008] = 16'hF000;
        mem[16'h0010] = 16'h6BBB;
        mem[16'h0040] = 16'h5AAA;
        mem[16'hFFFE] = 16'h1000;

        // Reset
        drive(1, 0, 0, 0, 16'h0);
        cyc();
        chk("rst_pc", pc, 16'h0000);
        chk("rst_valid", {15'd0, if_id_valid}, 16'h0);
        chk("rst_halted", {15'd0, halted}, 16'h0);
        chk("rst_count", fetch_count, 16'h0);

        // Straight-line fetch
        drive(0, 0, 0, 0, 16'h0);
        cyc();
        chk("sl1_instr", if_id_instr, 16'h1123);
        chk("sl1_pp2", if_id_pc_plus2, 16'h0002);
        cyc();
        chk("sl2_instr", if_id_instr, 16'h2456);
        chk("sl2_pp2", if_id_pc_plus2, 16'h0004);
        chk("sl2_pc", pc, 16'h0004);

        // Stall three cycles
        drive(0, 1, 0, 0, 16'h0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("stall_instr", if_id_instr, 16'h2456);
            chk("stall_pc", pc, 16'h0004);
            chk("stall_count", fetch_count, 16'h0002);
        end
        drive(0, 0, 0, 0, 16'h0);
        cyc();
        chk("sl3_instr", if_id_instr, 16'h3789);
        chk("sl3_pp2", if_id_pc_plus2, 16'h0006);
        chk("sl3_count", fetch_count, 16'h0003);

        // Redirect together with stall
        drive(0, 1, 0, 1, 16'h0041);
        #1;
        chk("rs_flush", {15'd0, flush}, 16'h1);
        cyc();
        drive(0, 0, 0, 0, 16'h0);
        chk("rs_pc", pc, 16'h0040);
        chk("rs_valid", {15'd0, if_id_valid}, 16'h0);
        cyc();
        chk("rs_instr", if_id_instr, 16'h5AAA);
        chk("rs_pp2", if_id_pc_plus2, 16'h0042);

        // HLT fetch, then redirect out of it
        drive(0, 0, 0, 1, 16'h0008);
        cyc();
        drive(0, 0, 0, 0, 16'h0);
        cyc();
        chk("hs_instr", if_id_instr, 16'hF000);
        chk("hs_valid", {15'd0, if_id_valid}, 16'h1);
        chk("hs_pc", pc, 16'h0008);
        cyc();
        chk("hs_bub", {15'd0, if_id_valid}, 16'h0);
        chk("hs_pc2", pc, 16'h0008);
        drive(0, 0, 0, 1, 16'h0010);
        cyc();
        drive(0, 0, 0, 0, 16'h0);
        cyc();
        chk("hs_esc", if_id_instr, 16'h6BBB);

        // HLT fetched, then hlt and redirect together
        drive(0, 0, 0, 1, 16'h0008);
        cyc();
        drive(0, 0, 0, 0, 16'h0);
        cyc();
        drive(0, 0, 1, 1, 16'h0020);
        #1;
        chk("hh_flush", {15'd0, flush}, 16'h0);
        cyc();
        drive(0, 0, 0, 0, 16'h0);
        chk("hh_halted", {15'd0, halted}, 16'h1);
        chk("hh_pc", pc, 16'h0008);
        drive(0, 0, 0, 1, 16'h0030);
        #1;
        chk("hh_ign_flush", {15'd0, flush}, 16'h0);
        cyc();
        chk("hh_ign_pc", pc, 16'h0008);
        drive(1, 0, 0, 0, 16'h0);
        cyc();
        chk("hh_rst_pc", pc, 16'h0000);
        chk("hh_rst_halted", {15'd0, halted}, 16'h0);

        // PC wrap
        drive(0, 0, 0, 1, 16'hFFFE);
        cyc();
        drive(0, 0, 0, 0, 16'h0);
        cyc();
        chk("wrap_instr", if_id_instr, 16'h1000);
        chk("wrap_pp2", if_id_pc_plus2, 16'h0000);
        chk("wrap_pc", pc, 16'h0000);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            drive($urandom_range(63) == 0, $urandom_range(3) == 0,
                  $urandom_range(31) == 0, $urandom_range(7) == 0,
                  16'($urandom));
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the 16-bit pipelined CPU. It owns the PC, drives the instruction-memory address, and registers the fetched instruction into IF/ID for the decode stage and the hazard detection unit. It consumes `stall` and `hlt` from the hazard detection unit and the branch redirect from EX. It produces the `flush` pulse that clears the hazard unit's halt-tracking flops.

## Interface
- `RESET_PC`, default 16'h0000: PC loaded on reset; bit 0 must be 0.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard-unit stall; freezes PC and IF/ID.
- `hlt`  in  1  hazard-unit latched halt (level); moves the block to HALTED.
- `redirect`  in  1  taken branch resolved in EX.
- `redirect_pc`  in  16  branch target; bit 0 ignored (treated as 0).
- `imem_addr`  out  16  instruction-memory address; equals `pc`.
- `imem_data`  in  16  instruction word at `imem_addr`, combinational same-cycle read.
- `if_id_instr`  out  16  registered instruction to decode.
- `if_id_pc_plus2`  out  16  registered PC+2 of that instruction.
- `if_id_valid`  out  1  1 = real instruction, 0 = bubble.
- `flush`  out  1  combinational; high in any cycle where a redirect is accepted.
- `pc`  out  16  current PC register.
- `halted`  out  1  registered; 1 in state HALTED.
- `fetch_count`  out  16  number of valid instructions written into IF/ID; saturates at 16'hFFFF.

## Operation
- Bubble: `if_id_instr` = 16'h0000, `if_id_valid` = 0, `if_id_pc_plus2` = 16'h0000.
- PC arithmetic is modulo 2^16: PC+2 wraps 16'hFFFE to 16'h0000. `redirect_pc` is loaded as {`redirect_pc`[15:1], 1'b0}.
- HLT detection uses `imem_data`[15:12] == 4'hF.
- State machine with three states:
  - RUN: normal fetch.
  - HLT_SEEN: an HLT has been fetched; PC is frozen at the HLT address and IF/ID is fed bubbles.
  - HALTED: terminal until `rst`.
- Per-cycle priority: `rst` > `hlt` > `redirect` > `stall` > state action.
  - `rst`: all state takes its reset value (see Timing).
  - `hlt` = 1, any state: state <= HALTED; PC holds; IF/ID <= bubble.
  - `redirect` = 1, state RUN or HLT_SEEN: PC <= target; IF/ID <= bubble; `flush` = 1; state <= RUN. This cancels a wrong-path HLT.
  - `stall` = 1: PC, IF/ID and state hold; `fetch_count` holds.
  - RUN, non-HLT word: IF/ID <= {`imem_data`, PC+2, valid=1}; PC <= PC+2.
  - RUN, HLT word: IF/ID <= {HLT word, PC+2, valid=1}; PC holds; state <= HLT_SEEN.
  - HLT_SEEN: IF/ID <= bubble; PC holds.
  - HALTED: IF/ID <= bubble; PC holds; `redirect` and `stall` are ignored; `flush` = 0.
- `fetch_count` increments exactly on edges where IF/ID is written with valid=1.

## Timing
- Reset values:
  - `pc` = `imem_addr` = `RESET_PC`
  - `if_id_instr` = 16'h0000, `if_id_pc_plus2` = 16'h0000, `if_id_valid` = 0
  - `halted` = 0, `fetch_count` = 0, state = RUN
- `flush` is 0 whenever `rst` = 1.
- Fetch latency: the word at PC in cycle n is visible on IF/ID in cycle n+1.
- Redirect asserted in cycle n:
  - cycle n+1: IF/ID holds a bubble and `imem_addr` = target.
  - cycle n+2: IF/ID holds the target instruction.
  - Exactly one bubble is inserted.
- Stall held for k cycles: IF/ID and PC are unchanged for k edges; fetch resumes on the first edge with `stall` = 0. No instruction is dropped or duplicated.
- Simultaneous `redirect` and `stall`: redirect wins; `flush` = 1.
- Simultaneous `hlt` and `redirect`: hlt wins; `flush` = 0.
- `halted` rises on the edge after `hlt` is first sampled high.
- `rst` during HLT_SEEN or HALTED returns the block to RUN at `RESET_PC` on that edge.

## Test plan
- Reset then straight-line code, `RESET_PC` = 0, imem[0..6] = 16'h1123, 16'h2456, 16'h3789, 16'h4000:
  - `if_id_instr` steps 1123 → 2456 → 3789 on consecutive cycles.
  - `if_id_pc_plus2` = 2, 4, 6.
  - `fetch_count` = 3 after three edges.
- `stall` high for 3 cycles while IF/ID = 2456 at pc = 4:
  - IF/ID stays 2456 and pc stays 4 for those 3 cycles.
  - The next edge loads 3789.
  - `fetch_count` does not advance during the stall.
- `redirect` = 1 with `redirect_pc` = 16'h0041 in the same cycle as `stall` = 1:
  - `flush` = 1 that cycle.
  - Next cycle: pc = 16'h0040 and `if_id_valid` = 0.
  - The cycle after: IF/ID = imem[0x40] with `if_id_pc_plus2` = 16'h0042.
- HLT fetched (imem[8] = 16'hF000):
  - IF/ID = F000 with valid = 1; pc frozen at 8; subsequent IF/ID are bubbles.
  - Later `redirect` to 16'h0010 returns to RUN and fetches imem[0x10].
- HLT fetched, then `hlt` = 1 with `redirect` = 1 in the same cycle:
  - `flush` = 0; `halted` = 1 next cycle; pc stays 8.
  - Further `redirect` pulses are ignored.
  - `rst` restores pc = `RESET_PC` and `halted` = 0.
- PC wrap: `redirect_pc` = 16'hFFFE, imem[FFFE] = 16'h1000:
  - IF/ID = 1000 with `if_id_pc_plus2` = 16'h0000.
  - pc = 16'h0000 afterwards.
